// File: rtl/mlp_sequencer_if.sv
// Handshake and index bus between the MLP sequencer and the MAC datapath.
// The slave modport is the sequencer side. The master modport is the datapath or
// controller side that supplies start, the label and the score.
interface mlp_sequencer_if #(
    parameter int clog2_number_of_inputs     = 6,
    parameter int clog2_size_of_hidden_layer = 5,
    parameter int clog2_size_of_output_layer = 4,
    parameter int clog2_number_of_test_cases = 10,
    parameter int score_w                    = 16
);
    logic                                  start;
    logic [clog2_size_of_output_layer-1:0] label_in;
    logic signed [score_w-1:0]             score_in;
    logic [clog2_number_of_test_cases-1:0] test_idx;
    logic                                  layer;
    logic [clog2_size_of_hidden_layer-1:0] neuron_idx;
    logic [clog2_number_of_inputs-1:0]     input_idx;
    logic                                  mac_en;
    logic                                  mac_clr;
    logic                                  hidden_wr;
    logic                                  busy;
    logic                                  done;
    logic [clog2_number_of_test_cases-1:0] accuracy;

    modport master (
        output start, label_in, score_in,
        input  test_idx, layer, neuron_idx, input_idx, mac_en, mac_clr,
               hidden_wr, busy, done, accuracy
    );

    modport slave (
        input  start, label_in, score_in,
        output test_idx, layer, neuron_idx, input_idx, mac_en, mac_clr,
               hidden_wr, busy, done, accuracy
    );
endinterface

// File: rtl/mlp_sequencer.sv
// Control sequencer for a two-layer MLP inference engine. It walks the hidden-layer
// and output-layer MACs and runs an argmax over the output scores. It also counts
// the test cases that are classified correctly.
// Optional feature: define MLP_SEQ_ABORT_EN to add an abort input. That input ends
// a busy run early, and the accuracy stays at the value reached so far.
module mlp_sequencer #(
    parameter int number_of_inputs           = 62,
    parameter int size_of_hidden_layer       = 30,
    parameter int size_of_output_layer       = 10,
    parameter int number_of_test_cases       = 750,
    parameter int clog2_number_of_inputs     = 6,
    parameter int clog2_size_of_hidden_layer = 5,
    parameter int clog2_size_of_output_layer = 4,
    parameter int clog2_number_of_test_cases = 10,
    parameter int score_w                    = 16
) (
    input logic clk,
    input logic rst,
`ifdef MLP_SEQ_ABORT_EN
    input logic abort,
`endif
    mlp_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, HID_MAC, HID_WB, OUT_MAC, OUT_CMP, NEXT_TEST, DONE
    } state_t;

    // The output layer reuses input_idx for its fan-in and neuron_idx for its neurons.
    localparam logic [clog2_number_of_inputs-1:0] last_in =
        clog2_number_of_inputs'(number_of_inputs - 1);
    localparam logic [clog2_number_of_inputs-1:0] last_hid_in =
        clog2_number_of_inputs'(size_of_hidden_layer - 1);
    localparam logic [clog2_size_of_hidden_layer-1:0] last_hid =
        clog2_size_of_hidden_layer'(size_of_hidden_layer - 1);
    localparam logic [clog2_size_of_hidden_layer-1:0] last_out =
        clog2_size_of_hidden_layer'(size_of_output_layer - 1);
    localparam logic [clog2_number_of_test_cases-1:0] last_test =
        clog2_number_of_test_cases'(number_of_test_cases - 1);
    localparam logic [clog2_number_of_test_cases-1:0] max_acc =
        clog2_number_of_test_cases'(number_of_test_cases);

    state_t                                state, state_nxt;
    logic [clog2_number_of_test_cases-1:0] test_idx;
    logic [clog2_size_of_hidden_layer-1:0] neuron_idx;
    logic [clog2_number_of_inputs-1:0]     input_idx;
    logic [clog2_number_of_test_cases-1:0] accuracy;
    logic signed [score_w-1:0]             best;
    logic [clog2_size_of_output_layer-1:0] best_idx;
    logic                                  busy_state;
    logic                                  abort_hit;

    assign busy_state = (state != IDLE) && (state != DONE);
`ifdef MLP_SEQ_ABORT_EN
    assign abort_hit = abort && busy_state;
`else
    assign abort_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.start) state_nxt = HID_MAC;
            HID_MAC:   if (input_idx == last_in) state_nxt = HID_WB;
            HID_WB:    state_nxt = (neuron_idx == last_hid) ? OUT_MAC : HID_MAC;
            OUT_MAC:   if (input_idx == last_hid_in) state_nxt = OUT_CMP;
            OUT_CMP:   state_nxt = (neuron_idx == last_out) ? NEXT_TEST : OUT_MAC;
            NEXT_TEST: state_nxt = (test_idx == last_test) ? DONE : HID_MAC;
            DONE:      if (!bus.start) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (abort_hit) state_nxt = DONE;
    end

    // Index counters, argmax tracking and accuracy count
    always_ff @(posedge clk) begin
        if (!rst) begin
            test_idx   <= '0;
            neuron_idx <= '0;
            input_idx  <= '0;
            accuracy   <= '0;
            best       <= '0;
            best_idx   <= '0;
        end else if (abort_hit) begin
            // Leave the indices at zero in DONE. test_idx and accuracy keep their values.
            neuron_idx <= '0;
            input_idx  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    test_idx   <= '0;
                    neuron_idx <= '0;
                    input_idx  <= '0;
                    accuracy   <= '0;
                end
                HID_MAC: input_idx  <= (input_idx == last_in) ? '0 : input_idx + 1'b1;
                HID_WB:  neuron_idx <= (neuron_idx == last_hid) ? '0 : neuron_idx + 1'b1;
                OUT_MAC: input_idx  <= (input_idx == last_hid_in) ? '0 : input_idx + 1'b1;
                OUT_CMP: begin
                    // The strict compare keeps the lower index when two scores tie.
                    if ((neuron_idx == '0) || (bus.score_in > best)) begin
                        best     <= bus.score_in;
                        best_idx <= clog2_size_of_output_layer'(neuron_idx);
                    end
                    neuron_idx <= (neuron_idx == last_out) ? '0 : neuron_idx + 1'b1;
                end
                NEXT_TEST: begin
                    if ((best_idx == bus.label_in) && (accuracy != max_acc))
                        accuracy <= accuracy + 1'b1;
                    // test_idx stays on the last test so that DONE reports it.
                    if (test_idx != last_test) test_idx <= test_idx + 1'b1;
                end
                DONE: if (!bus.start) test_idx <= '0;
                default: ;
            endcase
        end
    end

    // Output decode from the current state
    always_comb begin
        bus.mac_en    = (state == HID_MAC) || (state == OUT_MAC);
        bus.mac_clr   = ((state == HID_MAC) || (state == OUT_MAC)) && (input_idx == '0);
        bus.hidden_wr = (state == HID_WB);
        bus.layer     = (state == OUT_MAC) || (state == OUT_CMP);
        bus.busy      = busy_state;
        bus.done      = (state == DONE);
    end

    assign bus.test_idx   = test_idx;
    assign bus.neuron_idx = neuron_idx;
    assign bus.input_idx  = input_idx;
    assign bus.accuracy   = accuracy;
endmodule

// File: tb/tb_mlp_sequencer.sv
// Scoreboard bench for mlp_sequencer using the small configuration: 3 inputs,
// 2 hidden neurons, 3 output neurons and 2 tests, so each test takes 18 cycles.
module tb_mlp_sequencer;
    localparam int NI = 3, NH = 2, NO = 3, NT = 2;
    localparam int WI = 2, WH = 2, WO = 2, WT = 2, SW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
`ifdef MLP_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif

    mlp_sequencer_if #(.clog2_number_of_inputs(WI), .clog2_size_of_hidden_layer(WH),
        .clog2_size_of_output_layer(WO), .clog2_number_of_test_cases(WT),
        .score_w(SW)) bus ();

    mlp_sequencer #(
        .number_of_inputs(NI), .size_of_hidden_layer(NH), .size_of_output_layer(NO),
        .number_of_test_cases(NT), .clog2_number_of_inputs(WI),
        .clog2_size_of_hidden_layer(WH), .clog2_size_of_output_layer(WO),
        .clog2_number_of_test_cases(WT), .score_w(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef MLP_SEQ_ABORT_EN
        .abort(abort),
`endif
        .bus(bus)
    );

    // Score and label response tables, indexed by the indices the sequencer presents.
    logic signed [SW-1:0] score_tab [4][4];
    logic [WO-1:0]        label_tab [4];
    assign bus.score_in = score_tab[bus.test_idx][bus.neuron_idx];
    assign bus.label_in = label_tab[bus.test_idx];

    typedef struct {
        int acc;
        int cyc;
        int nclr;
        int nwr;
        int tidx;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    function automatic int outs();
        return int'({bus.test_idx, bus.layer, bus.neuron_idx, bus.input_idx, bus.mac_en,
                     bus.mac_clr, bus.hidden_wr, bus.busy, bus.done, bus.accuracy});
    endfunction

    // Monitor: measures each run and checks it against the scoreboard when done rises
    int   cyc = 0, nclr = 0, nwr = 0;
    logic busy_q = 1'b0, done_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.busy && !busy_q) begin
            cyc = 0; nclr = 0; nwr = 0;
        end else begin
            cyc++;
        end
        if (bus.mac_clr)   nclr++;
        if (bus.hidden_wr) nwr++;
        if (bus.done && !done_q) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("accuracy", int'(bus.accuracy), e.acc);
                check("done_test_idx", int'(bus.test_idx), e.tidx);
                check("done_idx_zero", int'({bus.neuron_idx, bus.input_idx}), 0);
                check("done_busy", int'(bus.busy), 0);
                if (e.cyc >= 0) begin
                    check("run_cycles", cyc, e.cyc);
                    check("mac_clr_count", nclr, e.nclr);
                    check("hidden_wr_count", nwr, e.nwr);
                end
            end
        end
        busy_q = bus.busy;
        done_q = bus.done;
    end

    task automatic wait_done(input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) check("done_timeout", 0, 1);
    endtask

    // Waits for the MAC phase of test 1 in the given layer
    task automatic wait_mac_t1(input logic lay, input int budget);
        int n = 0;
        while (!(bus.mac_en && bus.layer == lay && bus.test_idx == 2'd1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("mac_t1_timeout", 0, 1);
    endtask

    task automatic set_test(input int t, input int s0, input int s1, input int s2,
                            input int lbl);
        score_tab[t][0] = SW'(s0);
        score_tab[t][1] = SW'(s1);
        score_tab[t][2] = SW'(s2);
        score_tab[t][3] = '0;
        label_tab[t]    = WO'(lbl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        for (int t = 0; t < 4; t++) set_test(t, 0, 0, 0, 0);
        set_test(0, 5, -3, 5, 0);
        set_test(1, -8, -2, -7, 1);
        repeat (2) @(negedge clk);
        check("reset_outputs", outs(), 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_without_start", outs(), 0);

        // Run A: both tests are classified correctly (test 0 is a tie that resolves to index 0).
        sb.push_back('{2, 36, 10, 4, 1});
        bus.start = 1'b1;
        wait_done(100);
        repeat (3) @(negedge clk);
        check("done_hold", int'(bus.done), 1);
        check("acc_hold", int'(bus.accuracy), 2);
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_after_done", int'({bus.done, bus.busy, bus.test_idx, bus.neuron_idx,
                                       bus.input_idx}), 0);

        // Run B: test 0 is a miss, so the accuracy is cleared and counts only test 1.
        set_test(0, 1, 2, 3, 0);
        sb.push_back('{1, 36, 10, 4, 1});
        bus.start = 1'b1;
        wait_done(100);
        bus.start = 1'b0;
        @(negedge clk);

        // Run C: reset arrives during OUT_MAC of test 1.
        set_test(0, 5, -3, 5, 0);
        bus.start = 1'b1;
        wait_mac_t1(1'b1, 100);
        rst = 1'b0;
        @(negedge clk);
        check("midrun_reset_outputs", outs(), 0);
        rst = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_after_reset", int'({bus.busy, bus.done}), 0);

        // Run D: after the reset, a full run completes.
        sb.push_back('{2, 36, 10, 4, 1});
        bus.start = 1'b1;
        wait_done(100);
        bus.start = 1'b0;
        @(negedge clk);

`ifdef MLP_SEQ_ABORT_EN
        // Run E: abort during HID_MAC of test 1, after test 0 was classified correctly.
        sb.push_back('{1, -1, 0, 0, 1});
        bus.start = 1'b1;
        wait_mac_t1(1'b0, 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done", int'(bus.done), 1);
        bus.start = 1'b0;
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
